key_event_filter: RTL and testbench
===================================

Name: key_event_filter

Overview:
Sits directly downstream of the matrix keypad scanner and upstream of the game/scoring logic. It takes the scanner's raw key-pressed flag and 4-bit key code, and debounces them. It emits exactly one event per physical press, so a held key never scores repeatedly. Events are buffered in a small FIFO with a valid/ready handshake, so presses arriving while game logic is busy are not lost.

Parameters:
DEB_W, 20, width of debounce counter
DEB_CYCLES, 500000, consecutive stable i_clk cycles required to accept a press or release (10 ms at 50 MHz); legal range 1 .. 2^DEB_W-1
FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW (default 4)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_key_down  in  1  raw pressed flag from scanner (1 = some key down)
i_key_code  in  4  raw key code from scanner; meaningful only while i_key_down=1
i_ready  in  1  consumer accepts head event this cycle when o_valid=1
i_clr_ovf  in  1  synchronous clear of o_overflow
o_valid  out  1  FIFO non-empty
o_code  out  4  head-of-FIFO key code (show-ahead); 0 when empty
o_held  out  1  debounced key-held status (1 in HELD and REL_CHK)
o_count  out  FIFO_AW+1  current FIFO occupancy
o_overflow  out  1  sticky flag: a press event was dropped because the FIFO was full

Behaviour:
- Reset (async, i_rst_n=0): FSM=IDLE, debounce counter=0, captured code=0, FIFO pointers/occupancy=0, o_valid=0, o_code=0, o_held=0, o_count=0, o_overflow=0. Reset asserted mid-debounce or with a non-empty FIFO discards everything; after release, the first event needs a full new press qualification.
- Inputs are double-flop synchronised before use; all latencies below are counted from the synchronised signals (+2 cycles from the pins).
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE: key_down=1 -> PRESS_CHK; capture code, counter=0.
  - PRESS_CHK, key_down=0 -> IDLE, no event.
  - PRESS_CHK, code != captured -> stay; recapture code, counter=0.
  - PRESS_CHK, otherwise -> counter++. When counter reaches DEB_CYCLES-1 -> HELD, and a push request for the captured code is issued that same cycle.
  - HELD: key_down=0 -> REL_CHK, counter=0. Code changes while down are ignored (no event, no recapture).
  - REL_CHK: key_down=1 -> HELD, counter=0, no new event. Otherwise counter++; at DEB_CYCLES-1 -> IDLE.
- Only the IDLE->PRESS_CHK->HELD path generates events. Holding a key yields exactly one event; auto-repeat is not supported.
- FIFO behaviour:
  - Push writes the captured code at the tail. Pop occurs when o_valid & i_ready; pop advances the head.
  - o_code and o_valid update the cycle after the push/pop edge. An event enters o_code one cycle after the qualifying edge.
  - Pointers wrap modulo 2^FIFO_AW. Occupancy is an explicit counter.
  - Push and pop in the same cycle: both performed, occupancy unchanged. This applies even when full: the push is accepted because the pop frees a slot.
  - Push while full without pop: the event is dropped, o_overflow<=1, and FIFO contents are unchanged.
  - Pop while empty: ignored; occupancy never underflows.
- o_overflow: set by a dropped push and cleared by i_clr_ovf. If both occur in the same cycle, set wins.
- i_ready is ignored when o_valid=0. o_code=0 whenever empty.

Test Plan:
(All with DEB_CYCLES=4, FIFO_AW=2.)
1. Clean press: hold key_down=1 with code 0x7 for 10 cycles, i_ready=1. Response: o_valid pulses 1 cycle with o_code=0x7, o_held=1; exactly one event.
2. Bounce: key_down toggles 1,0,1,0 every cycle, then stays 1 with code 0x3. Response: single event 0x3, emitted 4 cycles after the line goes stable.
3. Code change in PRESS_CHK: code 0x2 for 2 cycles, then 0x9 stable. Response: one event 0x9, counted from the change; no 0x2 event.
4. FIFO fill and overflow: i_ready=0; 5 clean presses with codes 1,2,3,4,5. Response: o_count=4, o_overflow=1, and draining yields 1,2,3,4. Then i_clr_ovf -> o_overflow=0.
5. Full with simultaneous push/pop: FIFO full, i_ready=1 on the push cycle. Response: push accepted, o_count stays 4, o_overflow stays 0.
6. Reset mid-operation: 3 events queued and PRESS_CHK active, assert i_rst_n=0 asynchronously. Response: o_valid=0, o_count=0, o_held=0 immediately; no event until a new 4-cycle-stable press.

Source files
------------

// File: rtl/key_event_filter_if.sv
// Scanner-in / event-out bundle for key_event_filter.
// slave is the filter side, master is the scanner/game-logic side.
interface key_event_filter_if #(
    parameter int FIFO_AW = 2
);
    logic               i_key_down;
    logic [3:0]         i_key_code;
    logic               i_ready;
    logic               i_clr_ovf;
    logic               o_valid;
    logic [3:0]         o_code;
    logic               o_held;
    logic [FIFO_AW:0]   o_count;
    logic               o_overflow;

    modport master (
        output i_key_down, i_key_code, i_ready, i_clr_ovf,
        input  o_valid, o_code, o_held, o_count, o_overflow
    );

    modport slave (
        input  i_key_down, i_key_code, i_ready, i_clr_ovf,
        output o_valid, o_code, o_held, o_count, o_overflow
    );
endinterface

// File: rtl/key_event_filter.sv
// Debounces the keypad scanner output into one event per physical press and
// queues events in a small show-ahead FIFO with a valid/ready consumer port.
module key_event_filter #(
    parameter int DEB_W      = 20,
    parameter int DEB_CYCLES = 500000,
    parameter int FIFO_AW    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    key_event_filter_if.slave kif
);
    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef struct packed {
        logic       down;
        logic [3:0] code;
    } key_s;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;

    // Only the asynchronous scanner lines are synchronised; ready/clear come
    // from the consumer's own clock domain and must act in the same cycle.
    key_s [1:0]       sync_pipe;
    key_s             key;
    state_e           state;
    logic [DEB_W-1:0] cnt;
    logic [3:0]       cap;
    logic             held;

    logic [DEPTH-1:0][3:0] mem;
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      count;
    logic                  ovf;
    logic                  push_req, empty, full, wr_en, rd_en, drop;

    assign key = sync_pipe[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe[0] <= '{down: kif.i_key_down, code: kif.i_key_code};
            sync_pipe[1] <= sync_pipe[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            held  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (key.down) begin
                    state <= PRESS_CHK;
                    cap   <= key.code;
                    cnt   <= '0;
                end
                PRESS_CHK: begin
                    if (!key.down) begin
                        state <= IDLE;
                    end else if (key.code != cap) begin
                        cap <= key.code;
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= HELD;
                        held  <= 1'b1;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
                HELD: if (!key.down) begin
                    state <= REL_CHK;
                    cnt   <= '0;
                end
                REL_CHK: begin
                    if (key.down) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push fires on the same edge that qualifies the press into HELD.
    assign push_req = (state == PRESS_CHK) && key.down && (key.code == cap) && (cnt == DEB_LAST);
    assign empty    = (count == '0);
    assign full     = (count == (FIFO_AW+1)'(DEPTH));
    assign rd_en    = !empty && kif.i_ready;
    assign wr_en    = push_req && (!full || rd_en);
    assign drop     = push_req && full && !rd_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= cap;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (rd_en)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
            if (drop)
                ovf <= 1'b1;
            else if (kif.i_clr_ovf)
                ovf <= 1'b0;
        end
    end

    assign kif.o_valid    = !empty;
    assign kif.o_code     = empty ? 4'h0 : mem[rd_ptr];
    assign kif.o_held     = held;
    assign kif.o_count    = count;
    assign kif.o_overflow = ovf;
endmodule

// File: tb/tb_key_event_filter.sv
// Randomised and directed bench for key_event_filter against a run-length /
// queue reference model of the debounce and event FIFO rules.
module tb_key_event_filter;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   miss = 0;

    key_event_filter_if #(.FIFO_AW(2)) kif ();

    key_event_filter #(.DEB_W(20), .DEB_CYCLES(DEB), .FIFO_AW(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .kif     (kif)
    );

    always #5 clk = ~clk;

    // Reference model: two-sample input delay, then run lengths of identical
    // samples; a run of DEB+1 qualifies a press (or a release when held).
    logic [4:0] m_s1, m_s2;
    bit         m_held;
    int         m_run;
    logic [3:0] m_last;
    logic [3:0] m_q[$];
    bit         m_ovf;
    logic [3:0] got[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_held = 0; m_run = 0; m_last = '0;
        m_q.delete(); m_ovf = 0;
    endtask

    task automatic model_edge(input bit down, input logic [3:0] code, input bit ready, input bit clr);
        bit         push = 0;
        bit         drop = 0;
        logic [4:0] smp  = m_s2;
        m_s2 = m_s1;
        m_s1 = {down, code};
        if (!m_held) begin
            if (smp[4]) begin
                if (m_run > 0 && smp[3:0] == m_last) m_run++;
                else begin m_run = 1; m_last = smp[3:0]; end
                if (m_run == DEB + 1) begin push = 1; m_held = 1; m_run = 0; end
            end else m_run = 0;
        end else begin
            if (smp[4]) m_run = 0;
            else begin
                m_run++;
                if (m_run == DEB + 1) begin m_held = 0; m_run = 0; end
            end
        end
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_last);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    function automatic logic [9:0] exp_vec();
        logic [3:0] c = (m_q.size() > 0) ? m_q[0] : 4'h0;
        return {m_q.size() > 0, c, m_held, 3'(m_q.size()), m_ovf};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {kif.o_valid, kif.o_code, kif.o_held, kif.o_count, kif.o_overflow};
    endfunction

    task automatic step(input bit down, input logic [3:0] code, input bit ready, input bit clr);
        kif.i_key_down = down;
        kif.i_key_code = code;
        kif.i_ready    = ready;
        kif.i_clr_ovf  = clr;
        if (kif.o_valid && ready) got.push_back(kif.o_code);
        @(posedge clk);
        model_edge(down, code, ready, clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        kif.i_key_down = 1'b1; kif.i_key_code = 4'h5; kif.i_ready = 1'b0; kif.i_clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (obs_vec() !== 10'h0) begin
            miss++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 10'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b0);
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL reset_idle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int rise = -1;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            step(i < 10, 4'h7, 1'b1, 1'b0);
            if (rise < 0 && kif.o_valid) rise = i;
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL clean_press i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        vecs++;
        if (got.size() != 1 || got[0] !== 4'h7 || rise != 6) begin
            miss++; $display("FAIL clean_events n=%0d rise=%0d exp n=1 code=7 rise=6", got.size(), rise);
        end
    endtask

    task automatic test_bounce();
        int rise = -1;
        got.delete();
        for (int i = 0; i < 26; i++) begin
            step((i < 4) ? (i % 2 == 0) : (i < 16), 4'h3, 1'b1, 1'b0);
            if (rise < 0 && kif.o_valid) rise = i;
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL bounce i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        vecs++;
        if (got.size() != 1 || got[0] !== 4'h3 || rise != 10) begin
            miss++; $display("FAIL bounce_events n=%0d rise=%0d exp n=1 code=3 rise=10", got.size(), rise);
        end
    endtask

    task automatic test_code_change();
        int rise = -1;
        got.delete();
        for (int i = 0; i < 24; i++) begin
            step(i < 14, (i < 2) ? 4'h2 : 4'h9, 1'b1, 1'b0);
            if (rise < 0 && kif.o_valid) rise = i;
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL code_change i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        vecs++;
        if (got.size() != 1 || got[0] !== 4'h9 || rise != 8) begin
            miss++; $display("FAIL code_change_events n=%0d rise=%0d exp n=1 code=9 rise=8", got.size(), rise);
        end
    endtask

    task automatic test_overflow();
        got.delete();
        for (int p = 1; p <= 5; p++)
            for (int i = 0; i < 17; i++) begin
                step(i < 8, 4'(p), 1'b0, 1'b0);
                vecs++;
                if (obs_vec() !== exp_vec()) begin
                    miss++; $display("FAIL fill p=%0d i=%0d got=%h exp=%h", p, i, obs_vec(), exp_vec());
                end
            end
        vecs++;
        if (kif.o_count !== 3'd4 || kif.o_overflow !== 1'b1) begin
            miss++; $display("FAIL full_status count=%0d ovf=%0b exp count=4 ovf=1", kif.o_count, kif.o_overflow);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        vecs++;
        if (got.size() != 4 || got[0] !== 4'h1 || got[1] !== 4'h2 || got[2] !== 4'h3 || got[3] !== 4'h4
            || kif.o_overflow !== 1'b1) begin
            miss++; $display("FAIL drain_order n=%0d ovf=%0b exp 1,2,3,4 ovf=1", got.size(), kif.o_overflow);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        vecs++;
        if (obs_vec() !== 10'h0 || obs_vec() !== exp_vec()) begin
            miss++; $display("FAIL clr_ovf got=%h exp=%h", obs_vec(), 10'h0);
        end
    endtask

    task automatic test_full_push_pop();
        got.delete();
        for (int p = 0; p < 5; p++)
            for (int i = 0; i < 17; i++) begin
                step(i < 8, 4'(10 + p), (p == 4) && (i == 6), 1'b0);
                vecs++;
                if (obs_vec() !== exp_vec()) begin
                    miss++; $display("FAIL push_pop p=%0d i=%0d got=%h exp=%h", p, i, obs_vec(), exp_vec());
                end
                if (p == 4 && i == 6) begin
                    vecs++;
                    if (kif.o_count !== 3'd4 || kif.o_overflow !== 1'b0 || got.size() != 1 || got[0] !== 4'hA) begin
                        miss++; $display("FAIL full_push_pop count=%0d ovf=%0b pops=%0d exp count=4 ovf=0 pops=1",
                                         kif.o_count, kif.o_overflow, got.size());
                    end
                end
            end
        for (int i = 0; i < 6; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        vecs++;
        if (got.size() != 5 || got[1] !== 4'hB || got[2] !== 4'hC || got[3] !== 4'hD || got[4] !== 4'hE) begin
            miss++; $display("FAIL push_pop_order n=%0d exp A,B,C,D,E", got.size());
        end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 17; i++) step(i < 8, 4'(p + 1), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h6, 1'b0, 1'b0);
        vecs++;
        if (kif.o_count !== 3'd3 || obs_vec() !== exp_vec()) begin
            miss++; $display("FAIL pre_reset got=%h exp=%h", obs_vec(), exp_vec());
        end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        vecs++;
        if (obs_vec() !== 10'h0) begin
            miss++; $display("FAIL async_reset got=%h exp=%h", obs_vec(), 10'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'h6, 1'b1, 1'b0);
            if (rise < 0 && kif.o_valid) rise = i;
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL post_reset i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        vecs++;
        if (rise != 6 || got.size() != 1 || got[0] !== 4'h6) begin
            miss++; $display("FAIL post_reset_event rise=%0d n=%0d exp rise=6 n=1", rise, got.size());
        end
        for (int i = 0; i < 10; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int         rem = 0;
        bit         d   = 0;
        logic [3:0] c   = '0;
        for (int i = 0; i < 1500; i++) begin
            if (rem == 0) begin
                d   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) c = 4'($urandom_range(0, 15));
                rem = $urandom_range(1, 9);
            end
            rem--;
            step(d, c, (i < 700) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
                 $urandom_range(0, 31) == 0);
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                miss++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_code_change();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
